// File: rtl/motoro3_pkg.sv
// Shared types and constants for the three-phase commutation sequencer.
// ST_FAULT exists only when STALL_DETECT_EN is defined.
package motoro3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEAD,
    ST_DRIVE
`ifdef STALL_DETECT_EN
    , ST_FAULT
`endif
  } state_t;

  // {phH, phL}, each {w,v,u}, indexed by commutation step
  localparam logic [5:0] PATTERN [6] = '{
    6'b001_010, 6'b001_100, 6'b010_100,
    6'b010_001, 6'b100_001, 6'b100_010
  };

  function automatic logic [2:0] next_step(input logic [2:0] cur, input logic dir);
    if (dir) return (cur >= 3'd5) ? 3'd0 : cur + 3'd1;
    else     return (cur == 3'd0) ? 3'd5 : cur - 3'd1;
  endfunction

endpackage

// File: rtl/motoro3_edge_sync.sv
// Two-flop synchroniser plus delay flop; emits a one-cycle pulse on a rising
// edge of an asynchronous input. Flops update on the falling clock edge.
module motoro3_edge_sync (
  input  logic clk50mhz,
  input  logic nRst,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(negedge clk50mhz or negedge nRst) begin
    if (!nRst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/motoro3_phase_seq.sv
// Six-step three-phase bridge sequencer with dead time between steps.
// Optional stall fault detection is enabled by defining STALL_DETECT_EN.
module motoro3_phase_seq
  import motoro3_pkg::*;
#(
  parameter int unsigned DEADTIME     = 4,
  parameter int unsigned STALL_CYCLES = 1024
) (
  input  logic       clk50mhz,
  input  logic       nRst,
  input  logic       clkM3,
  input  logic       enable,
  input  logic       dir,
  output logic [2:0] phH,
  output logic [2:0] phL,
  output logic [2:0] step,
  output logic       stepMissed,
  output logic       fault
);

  logic       rise;
  logic       stalled;
  state_t     state, state_nx;
  logic [7:0] dead_cnt, dead_nx;
  logic [2:0] step_nx, h_nx, l_nx;
  logic       missed_nx;

  motoro3_edge_sync u_sync (
    .clk50mhz (clk50mhz),
    .nRst     (nRst),
    .async_in (clkM3),
    .rise     (rise)
  );

`ifdef STALL_DETECT_EN
  logic [15:0] stall_cnt;

  always_ff @(negedge clk50mhz or negedge nRst) begin
    if (!nRst)                            stall_cnt <= '0;
    else if (state == ST_IDLE || rise)    stall_cnt <= '0;
    else if (stall_cnt != '1)             stall_cnt <= stall_cnt + 16'd1;
  end

  assign stalled = (stall_cnt >= 16'(STALL_CYCLES));
  assign fault   = (state == ST_FAULT);
`else
  assign stalled = 1'b0;
  assign fault   = 1'b0 & (STALL_CYCLES != 0);
`endif

  // Gate outputs are registered: all-off is the default every cycle, so no
  // path can ever present H and L of the same phase together.
  always_comb begin
    state_nx  = state;
    dead_nx   = dead_cnt;
    step_nx   = step;
    h_nx      = '0;
    l_nx      = '0;
    missed_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nx = ST_DEAD;
          dead_nx  = 8'(DEADTIME);
        end
      end
      ST_DEAD: begin
        if (!enable) begin
          state_nx = ST_IDLE;
        end else begin
          missed_nx = rise;
          if (dead_cnt <= 8'd1) begin
            state_nx     = ST_DRIVE;
            dead_nx      = '0;
            {h_nx, l_nx} = PATTERN[step];
          end else begin
            dead_nx = dead_cnt - 8'd1;
          end
        end
      end
      ST_DRIVE: begin
        if (!enable) begin
          state_nx = ST_IDLE;
        end else if (rise) begin
          step_nx  = next_step(step, dir);
          state_nx = ST_DEAD;
          dead_nx  = 8'(DEADTIME);
        end else begin
          {h_nx, l_nx} = PATTERN[step];
        end
      end
`ifdef STALL_DETECT_EN
      ST_FAULT: state_nx = ST_FAULT;
`endif
      default: state_nx = ST_IDLE;
    endcase
`ifdef STALL_DETECT_EN
    if (stalled && (state == ST_DEAD || state == ST_DRIVE)) begin
      state_nx  = ST_FAULT;
      step_nx   = step;
      h_nx      = '0;
      l_nx      = '0;
      missed_nx = 1'b0;
    end
`endif
  end

  always_ff @(negedge clk50mhz or negedge nRst) begin
    if (!nRst) begin
      state      <= ST_IDLE;
      dead_cnt   <= '0;
      step       <= '0;
      phH        <= '0;
      phL        <= '0;
      stepMissed <= 1'b0;
    end else begin
      state      <= state_nx;
      dead_cnt   <= dead_nx;
      step       <= step_nx;
      phH        <= h_nx;
      phL        <= l_nx;
      stepMissed <= missed_nx;
    end
  end

endmodule
